// File: rtl/riscv_test_mem_responder.sv
// Purpose : test-harness memory behind one core port; val/rdy requests, byte-lane
//           reads/writes into a word array, host preload port.
// Latency : LATENCY cycles (1..8) from request fire to memresp_val, one request per cycle.
// Backpr. : memreq_rdy drops during reset, block_req or load_en; the response channel
//           never stalls, so in-flight responses always emerge on schedule.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   memreq_msg/_val/_rdy        request {type[66], addr[65:34], len[33:32], data[31:0]}
//   memresp_msg/_val            response {type[34], len[33:32], data[31:0]}, val-only
//   block_req                   external back-pressure on the request channel
//   load_en/_addr/_data         full-word preload of the array
module riscv_test_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [66:0]       memreq_msg,
    input  logic              memreq_val,
    output logic              memreq_rdy,
    output logic [34:0]       memresp_msg,
    output logic              memresp_val,
    input  logic              block_req,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Word array; deliberately has no reset so contents survive reset.
    logic [31:0] mem_q [DEPTH];

    logic [LATENCY-1:0] pipe_val_q;
    logic [34:0]        pipe_msg_q [LATENCY];

    logic              fire;
    logic              req_type;
    logic [31:0]       req_addr;
    logic [1:0]        req_len;
    logic [31:0]       req_data;
    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_off;
    logic              unused_addr_hi;

    logic [3:0]        len_mask;   // bytes 0..n-1 of the request
    logic [3:0]        lane_be;    // lanes touched after the offset shift
    logic [31:0]       len_bits;
    logic [31:0]       lane_bits;
    logic [31:0]       rd_word;
    logic [31:0]       rd_data;
    logic [31:0]       wr_word;
    logic [34:0]       resp_d;

    assign memreq_rdy = !reset && !block_req && !load_en;
    assign fire       = memreq_val && memreq_rdy;

    assign req_type = memreq_msg[66];
    assign req_addr = memreq_msg[65:34];
    assign req_len  = memreq_msg[33:32];
    assign req_data = memreq_msg[31:0];
    assign req_idx  = req_addr[ADDR_W+1:2];
    assign req_off  = req_addr[1:0];

    // Upper address bits are ignored by design.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    always_comb begin
        len_mask = 4'hF;
        case (req_len)
            2'd1:    len_mask = 4'h1;
            2'd2:    len_mask = 4'h3;
            2'd3:    len_mask = 4'h7;
            default: len_mask = 4'hF;
        endcase
    end

    // 4-bit shift: lanes pushed beyond lane 3 fall off, so there is no wrap.
    assign lane_be = len_mask << req_off;

    always_comb begin
        len_bits  = '0;
        lane_bits = '0;
        for (int b = 0; b < 4; b++) begin
            len_bits[8*b +: 8]  = {8{len_mask[b]}};
            lane_bits[8*b +: 8] = {8{lane_be[b]}};
        end
    end

    // Combinational array read sees every write from earlier edges.
    assign rd_word = mem_q[req_idx];
    assign rd_data = (rd_word >> {req_off, 3'b000}) & len_bits;
    assign wr_word = (rd_word & ~lane_bits) | ((req_data << {req_off, 3'b000}) & lane_bits);

    // Idle cycles load an all-zero stage so bubbles carry a clean message.
    assign resp_d = fire ? {req_type, req_len, (req_type ? 32'h0 : rd_data)} : '0;

    // Preload and request writes are mutually exclusive because load_en clears rdy.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end else if (fire && req_type) begin
            mem_q[req_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_val_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_msg_q[i] <= '0;
            end
        end else begin
            pipe_val_q[0] <= fire;
            pipe_msg_q[0] <= resp_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_val_q[i] <= pipe_val_q[i-1];
                pipe_msg_q[i] <= pipe_msg_q[i-1];
            end
        end
    end

    assign memresp_val = pipe_val_q[LATENCY-1];
    assign memresp_msg = pipe_msg_q[LATENCY-1];

endmodule

// File: tb/tb_riscv_test_mem_responder.sv
// Purpose : drives two responders (LATENCY 2 and 3) with identical stimulus and
//           compares both against a byte-level reference model and directed constants.
// Latency : n/a (bench).
// Backpr. : block_req / load_en / reset applied directly and at random.
module tb_riscv_test_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        block_req;
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    logic        rdy2, val2, rdy3, val3;
    logic [34:0] msg2, msg3;

    riscv_test_mem_responder #(.ADDR_W(12), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(rdy2),
        .memresp_msg(msg2), .memresp_val(val2),
        .block_req(block_req), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    riscv_test_mem_responder #(.ADDR_W(12), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(rdy3),
        .memresp_msg(msg3), .memresp_val(val3),
        .block_req(block_req), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    // Reference state: memory image and per-cycle expected response history.
    logic [31:0] mm [4096];
    bit          hval [8192];
    logic [34:0] hmsg [8192];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Byte-at-a-time model of one request.
    task automatic model_access(input logic [66:0] m, output logic [34:0] r);
        int          n, off, w, lane;
        logic [31:0] word, d;
        n    = (m[33:32] == 2'd0) ? 4 : int'(m[33:32]);
        off  = int'(m[35:34]);
        w    = int'(m[47:36]);
        word = mm[w];
        d    = 32'h0;
        for (int k = 0; k < n; k++) begin
            lane = off + k;
            if (lane < 4) begin
                if (m[66]) word[8*lane +: 8] = m[8*k +: 8];
                else       d[8*k +: 8]     = word[8*lane +: 8];
            end
        end
        mm[w] = word;
        r = {m[66], m[33:32], d};
    endtask

    // One clock cycle with the currently driven inputs; checks rdy, then outputs.
    task automatic step();
        bit          exp_rdy, fire;
        logic [34:0] r;
        #1;
        if (reset) begin
            for (int i = 0; i <= cyc; i++) hval[i] = 1'b0;
            chk("rst_val2", 64'(val2), 64'(0));
            chk("rst_msg2", 64'(msg2), 64'(0));
            chk("rst_val3", 64'(val3), 64'(0));
            chk("rst_msg3", 64'(msg3), 64'(0));
        end
        exp_rdy = !reset && !block_req && !load_en;
        chk("rdy2", 64'(rdy2), 64'(exp_rdy));
        chk("rdy3", 64'(rdy3), 64'(exp_rdy));
        fire = memreq_val && exp_rdy;
        r = '0;
        if (fire) model_access(memreq_msg, r);
        if (load_en) mm[load_addr] = load_data;
        hval[cyc] = fire;
        hmsg[cyc] = r;
        @(posedge clk);
        cyc++;
        #1;
        begin
            bit e2, e3;
            e2 = (cyc >= 2) ? hval[cyc-2] : 1'b0;
            e3 = (cyc >= 3) ? hval[cyc-3] : 1'b0;
            chk("val2", 64'(val2), 64'(e2));
            chk("val3", 64'(val3), 64'(e3));
            if (e2) chk("msg2", 64'(msg2), 64'(hmsg[cyc-2]));
            if (e3) chk("msg3", 64'(msg3), 64'(hmsg[cyc-3]));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        memreq_val = 1'b0;
        block_req  = 1'b0;
        load_en    = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        idle();
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        memreq_val = 1'b1;
        memreq_msg = {t, a, l, d};
        step();
        memreq_val = 1'b0;
    endtask

    // Read, then check the response on both latencies against a fixed value.
    task automatic read_check(input string tag, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        send(1'b0, a, l, 32'h0);
        step();
        chk({tag, "_v2"}, 64'(val2), 64'(1));
        chk({tag, "_m2"}, 64'(msg2), 64'({1'b0, l, d}));
        step();
        chk({tag, "_v3"}, 64'(val3), 64'(1));
        chk({tag, "_m3"}, 64'(msg3), 64'({1'b0, l, d}));
    endtask

    initial begin
        logic [31:0] a;
        reset      = 1'b1;
        memreq_msg = '0;
        load_addr  = '0;
        load_data  = '0;
        idle();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // Fill the words the random phase uses.
        for (int i = 0; i < 64; i++) preload(12'(i), $urandom);

        // Preload and read.
        preload(12'd5, 32'hDEADBEEF);
        read_check("pre_rd", 32'h14, 2'd0, 32'hDEADBEEF);

        // Sub-word write and reads.
        preload(12'd8, 32'h11223344);
        send(1'b1, 32'h21, 2'd2, 32'h0000ABCD);
        read_check("sub_w", 32'h20, 2'd0, 32'h11ABCD44);
        read_check("sub_b", 32'h22, 2'd1, 32'h000000AB);

        // Boundary drop: bytes beyond lane 3 must not reach word 4.
        preload(12'd3, 32'h0);
        preload(12'd4, 32'h55667788);
        send(1'b1, 32'h0F, 2'd0, 32'hAABBCCDD);
        read_check("bnd_w3", 32'h0C, 2'd0, 32'hDD000000);
        read_check("bnd_w4", 32'h10, 2'd0, 32'h55667788);

        // Back-to-back reads with block_req in the third cycle.
        for (int i = 0; i < 6; i++) begin
            memreq_val = 1'b1;
            memreq_msg = {1'b0, 32'(4 * (i + 1)), 2'd0, 32'h0};
            block_req  = (i == 2);
            step();
        end
        idle();
        step(); step(); step();

        // Reset mid-flight: the write sticks, responses are discarded.
        preload(12'd10, 32'h01020304);
        send(1'b1, 32'h28, 2'd0, 32'hCAFEF00D);
        send(1'b0, 32'h28, 2'd0, 32'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        read_check("rst_keep", 32'h28, 2'd0, 32'hCAFEF00D);

        // Preload precedence: request held across a load cycle.
        memreq_val = 1'b1;
        memreq_msg = {1'b0, 32'h30, 2'd0, 32'h0};
        load_en    = 1'b1;
        load_addr  = 12'd12;
        load_data  = 32'h600DF00D;
        step();
        load_en = 1'b0;
        read_check("ld_prec", 32'h30, 2'd0, 32'h600DF00D);

        // Randomized traffic over words 0..63 with random upper address bits.
        for (int i = 0; i < 1500; i++) begin
            a          = $urandom;
            a[13:8]    = 6'd0;
            memreq_val = ($urandom_range(0, 9) < 7);
            memreq_msg = {1'($urandom), a, 2'($urandom), 32'($urandom)};
            block_req  = ($urandom_range(0, 5) == 0);
            load_en    = ($urandom_range(0, 7) == 0);
            load_addr  = 12'($urandom_range(0, 63));
            load_data  = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step(); step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_test_mem_responder.md
# riscv_test_mem_responder

Single-port memory responder that sits on the far side of one core memory port (imem or dmem) in the test harness. It accepts packed requests under a val/rdy handshake and applies reads and writes to an internal word array. It returns packed responses in request order a fixed number of cycles later, on a val-only response channel that the core always accepts. A host-side preload port fills the array before a program runs.

## Interface
- `ADDR_W`, 12: word-index width; the array holds 2^ADDR_W 32-bit words, indexed by `addr[ADDR_W+1:2]`; upper address bits are ignored.
- `LATENCY`, 2: cycles from request acceptance to response valid; legal range 1..8.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `memreq_msg` input 67: request, packed `{type[66], addr[65:34], len[33:32], data[31:0]}`. type 0 is read, 1 is write. len 0 means 4 bytes; 1, 2 and 3 mean that many bytes.
- `memreq_val` input 1: request valid.
- `memreq_rdy` output 1: responder can accept a request this cycle.
- `memresp_msg` output 35: response, packed `{type[34], len[33:32], data[31:0]}`.
- `memresp_val` output 1: response valid. There is no ready signal; the consumer always takes the response.
- `block_req` input 1: bench-driven back-pressure; while high, `memreq_rdy` is 0.
- `load_en` input 1: preload write strobe.
- `load_addr` input ADDR_W: preload word index.
- `load_data` input 32: preload word.

## Operation
- `memreq_rdy` = `!reset && !block_req && !load_en`. It is combinational and never depends on `memreq_val`.
- A request fires on a cycle where `memreq_val && memreq_rdy`.
- Byte offset is `off = addr[1:0]`. Byte count `n` = 4 when len=0, otherwise `n` = len.
- **Write:** byte lanes `off .. min(off+n, 4)-1` take `data[7:0]`, `data[15:8]`, ... in order. Bytes that would land beyond lane 3 are dropped; there is no wrap into the next word. The response is type=1, same len, data=0.
- **Read:** the response word is the stored word shifted right by `8*off`. Bytes at and above byte `n` are zeroed, as are bytes past lane 3. The response is type=0, same len, data=that value. Sign extension is the consumer's job.
- The read samples the array at the fire edge, after any write from the previous cycle is visible. A read that fires one cycle after a write to the same word returns the written data.
- **Preload:** on a cycle with `load_en`=1, the word at `load_addr` gets `load_data` in full. `memreq_rdy` is 0 that cycle, so a request and a preload never collide.
- **Response pipeline:** a LATENCY-stage shift register of {valid, type, len, data}. The fire cycle loads stage 0. Every stage advances every cycle unconditionally. The last stage drives `memresp_msg` and `memresp_val`.
- Up to LATENCY requests can be in flight; full throughput is one request per cycle. No occupancy limit is needed because the response channel never stalls.
- Array contents have no reset value, are not cleared by reset, and are retained across reset.

## Timing
- A request that fires at edge `t` gives `memresp_val`=1 during the cycle after edge `t+LATENCY-1`, i.e. exactly LATENCY cycles later. With LATENCY=1, the response is valid in the cycle following acceptance.
- Responses come out in acceptance order. A cycle with no fire inserts a bubble (val=0) exactly LATENCY cycles later.
- Reset asserted: every pipeline valid bit clears immediately (asynchronously), so `memresp_val`=0 and `memresp_msg`=0. In-flight responses are discarded, while writes that already fired stay in the array.
- Reset deasserted: `memreq_rdy` can be 1 in the first cycle after reset. The first response appears no earlier than LATENCY cycles after the first fire.
- `block_req` and `load_en` only gate acceptance. Responses already in the pipeline still emerge on schedule.

## Test plan
- **Preload and read:** preload word 5 with 0xDEADBEEF, then read addr 0x14 len 0 at LATENCY=2. Required: `memresp_val` exactly 2 cycles after fire, with msg {0, 0, 0xDEADBEEF}.
- **Sub-word write/read:** write addr 0x21 len 2 data 0x0000ABCD over word 8 preloaded with 0x11223344, then read addr 0x20 len 0. Required: 0x11ABCD44. Read addr 0x22 len 1. Required: 0x000000AB.
- **Boundary drop:** write addr 0x0F len 0 data 0xAABBCCDD over word 3 = 0, then read 0x0C len 0. Required: 0xDD000000, and word 4 unchanged.
- **Back-to-back throughput:** fire 6 reads on 6 consecutive cycles with `block_req` pulsed high on cycle 3. Required: five responses in order, a one-cycle val=0 bubble at the matching position, and `memreq_rdy`=0 in the blocked cycle.
- **Reset mid-flight:** fire a write then a read (LATENCY=3) and assert reset one cycle later. Required: `memresp_val` drops immediately and stays 0 through reset. After release, a read of the written word returns the new data.
- **Preload precedence:** hold `memreq_val`=1 while `load_en`=1. Required: `memreq_rdy`=0 and no response for that cycle. The request fires the next cycle.
